// File: rtl/apb5_wait_state_slave_if.sv
// APB5 completer bus bundle.
// Purpose : groups the APB5 request/response signals between a master and
//           the apb5_wait_state_slave completer.
// Signals : PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, PWUSER (master -> slave)
//           PRDATA, PREADY, PSLVERR, PRUSER, PBUSER             (slave -> master)
interface apb5_wait_state_slave_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int USER_DATA_WIDTH = DATA_WIDTH / 2,
  parameter int USER_RESP_WIDTH = 16
);
  logic                         PSEL;
  logic                         PENABLE;
  logic                         PWRITE;
  logic [ADDR_WIDTH-1:0]        PADDR;
  logic [DATA_WIDTH-1:0]        PWDATA;
  logic [DATA_WIDTH/8-1:0]      PSTRB;
  logic [2:0]                   PPROT;
  logic [USER_DATA_WIDTH-1:0]   PWUSER;
  logic [DATA_WIDTH-1:0]        PRDATA;
  logic                         PREADY;
  logic                         PSLVERR;
  logic [USER_DATA_WIDTH-1:0]   PRUSER;
  logic [USER_RESP_WIDTH-1:0]   PBUSER;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, PWUSER,
    input  PRDATA, PREADY, PSLVERR, PRUSER, PBUSER
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, PWUSER,
    output PRDATA, PREADY, PSLVERR, PRUSER, PBUSER
  );
endinterface

// File: rtl/apb5_wait_state_slave.sv
// APB5 completer with fixed wait states.
// Purpose : NUM_REGS word-spaced 32-bit registers starting at BASE_ADDR, each
//           with a user side-band word. Every access phase lasts WAIT_CYCLES+1
//           cycles; misaligned or out-of-range accesses answer PSLVERR.
//           PBUSER reports the access-phase length on every completion.
// Ports   : PCLK    - clock, rising edge
//           PRESETn - synchronous active-low reset
//           apb     - apb5_wait_state_slave_if.slave bus bundle
// Config  : define APB_SLV_PROT_CHECK_EN to reject unprivileged writes
//           (PPROT[0]=0) with PSLVERR; reads are unaffected.
module apb5_wait_state_slave #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    USER_DATA_WIDTH = DATA_WIDTH / 2,
  parameter int                    USER_RESP_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'h0000_3000,
  parameter int                    NUM_REGS        = 16,
  parameter int                    WAIT_CYCLES     = 2
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb5_wait_state_slave_if.slave apb
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(4 * NUM_REGS);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                     r_state, w_state_nxt;
  logic [7:0]                 r_wait_cnt, w_wait_cnt_nxt;
  logic                       r_write;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [STRB_W-1:0]          r_strb;
  logic [USER_DATA_WIDTH-1:0] r_wuser;
  logic [DATA_WIDTH-1:0]      r_regs [NUM_REGS];
  logic [USER_DATA_WIDTH-1:0] r_user [NUM_REGS];

  logic                       w_capture;
  logic                       w_ready;
  logic                       w_commit;
  logic                       w_err;
  logic                       w_prot_err;
  logic                       w_wr_en;
  logic [IDX_W-1:0]           w_idx;

`ifdef APB_SLV_PROT_CHECK_EN
  logic r_priv;
  always_ff @(posedge PCLK) begin
    if (!PRESETn)       r_priv <= 1'b0;
    else if (w_capture) r_priv <= apb.PPROT[0];
  end
  assign w_prot_err = r_write && !r_priv;
`else
  assign w_prot_err = 1'b0;
`endif

  assign w_capture = (r_state == S_IDLE) && apb.PSEL && !apb.PENABLE;
  assign w_ready   = (r_state == S_ACCESS) && (r_wait_cnt == 8'd0);
  assign w_commit  = w_ready && apb.PSEL && apb.PENABLE;
  assign w_err     = (r_addr[1:0] != 2'b00) ||
                     ({1'b0, r_addr} < LO_ADDR) ||
                     ({1'b0, r_addr} >= HI_ADDR) ||
                     w_prot_err;
  assign w_wr_en   = w_commit && r_write && !w_err;
  // BASE_ADDR is word aligned, so the low index bits of (addr - base) need no borrow from bits [1:0].
  assign w_idx     = r_addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    apb.PREADY     = w_ready;
    apb.PSLVERR    = 1'b0;
    apb.PRDATA     = '0;
    apb.PRUSER     = '0;
    apb.PBUSER     = '0;
    case (r_state)
      S_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          w_state_nxt    = S_ACCESS;
          w_wait_cnt_nxt = 8'(WAIT_CYCLES);
        end
      end
      S_ACCESS: begin
        if (!apb.PSEL) begin
          w_state_nxt = S_IDLE;
        end else if (apb.PENABLE) begin
          if (w_ready) w_state_nxt = S_IDLE;
          else         w_wait_cnt_nxt = r_wait_cnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_ready) begin
      apb.PSLVERR = w_err;
      apb.PBUSER  = USER_RESP_WIDTH'(WAIT_CYCLES + 1);
      if (!r_write && !w_err) begin
        apb.PRDATA = r_regs[w_idx];
        apb.PRUSER = r_user[w_idx];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_wuser <= '0;
    end else if (w_capture) begin
      r_write <= apb.PWRITE;
      r_addr  <= apb.PADDR;
      r_wdata <= apb.PWDATA;
      r_strb  <= apb.PSTRB;
      r_wuser <= apb.PWUSER;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_user[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (r_strb[b]) r_regs[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
      r_user[w_idx] <= r_wuser;
    end
  end
endmodule
